sonar_trigger_gen: RTL and testbench
====================================

SONAR_TRIGGER_GEN -- requirements
Module: sonar_trigger_gen

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter RISE_TIMEOUT, default 1_500_000, max cycles from trigger end to echo rise.
REQ-003 SHALL have parameter FALL_TIMEOUT, default 1_900_000, max echo-high cycles before abort.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 3_000_000, quiet time after each ping.
REQ-005 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  ping request, sampled only in IDLE.
REQ-008 SHALL have port echo  input  1  raw sensor echo line, asynchronous to clk.
REQ-009 SHALL have port trig  output  1  sensor trigger line.
REQ-010 SHALL have port echo_gate  output  1  high while echo measurement window is open (WAIT_FALL), for the downstream echo counter.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of echo phase.
REQ-013 SHALL have port timeout  output  1  valid with done; 1 = echo missing or too long.

Function
REQ-014 SHALL synchronize echo through two flip-flops (echo_s); all echo decisions use echo_s only.
REQ-015 SHALL implement states IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF using a single shared cycle counter wide enough for the largest parameter.
REQ-016 IDLE: start=1 at a clock edge SHALL enter TRIG; trig rises on that same edge (registered output, 1-cycle latency from start).
REQ-017 TRIG: trig SHALL stay high exactly TRIG_CYCLES cycles, then enter WAIT_RISE with counter cleared.
REQ-018 WAIT_RISE: echo_s=1 SHALL enter WAIT_FALL; counter reaching RISE_TIMEOUT-1 with echo_s=0 SHALL pulse done with timeout=1 and enter HOLDOFF.
REQ-019 WAIT_RISE: echo_s already high on entry (stale echo) SHALL be treated as a rise.
REQ-020 WAIT_FALL: echo_gate=1; echo_s=0 SHALL pulse done with timeout=0 and enter HOLDOFF; counter reaching FALL_TIMEOUT-1 with echo_s=1 SHALL pulse done with timeout=1 and enter HOLDOFF.
REQ-021 Simultaneous echo_s event and timeout count in the same cycle SHALL resolve in favour of the echo event (timeout=0 if echo fell).
REQ-022 HOLDOFF: SHALL last exactly HOLDOFF_CYCLES cycles regardless of echo, then enter IDLE.
REQ-023 start while busy=1 SHALL be ignored, not queued; start held high continuously SHALL produce back-to-back pings separated by HOLDOFF plus one IDLE cycle.
REQ-024 timeout SHALL hold its last value until the next done pulse.
REQ-025 done SHALL never be high for two consecutive cycles.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state IDLE, counter 0, echo synchronizer 0, trig=0, echo_gate=0, busy=0, done=0, timeout=0.
REQ-027 reset asserted mid-ping SHALL drop trig/echo_gate without waiting for a clock; after release the block SHALL accept start on the first edge.

Verification (TRIG_CYCLES=5, RISE_TIMEOUT=20, FALL_TIMEOUT=50, HOLDOFF_CYCLES=10)
REQ-028 Normal ping: start 1 cycle, echo high 8 cycles starting 6 cycles after trig falls -> trig high exactly 5 cycles, echo_gate high ~8 cycles (shifted 2 by sync), done pulse with timeout=0, busy drops 10 cycles after done+1.
REQ-029 No echo: start, echo held 0 -> done with timeout=1 exactly 20 cycles after entering WAIT_RISE, echo_gate never high.
REQ-030 Stuck echo: echo held 1 after rise -> done with timeout=1 after 50 cycles in WAIT_FALL; echo_gate falls same edge.
REQ-031 Busy rejection and continuous start: extra start pulses during TRIG/HOLDOFF -> exactly one ping; start held high -> second trig rises 1 cycle after busy falls.
REQ-032 Reset mid-TRIG (cycle 3) -> trig 0 without clock edge, all outputs 0; start after release -> full 5-cycle trig.
REQ-033 Tie case: echo falls on final WAIT_FALL count cycle -> done with timeout=0.

Source files
------------

// File: rtl/sonar_trigger_gen.sv
// Ultrasonic ranging sequencer: fires a trigger pulse, opens an echo measurement
// window, reports completion or timeout, then enforces a quiet holdoff period.
module sonar_trigger_gen #(
  parameter int TRIG_CYCLES    = 500,
  parameter int RISE_TIMEOUT   = 1_500_000,
  parameter int FALL_TIMEOUT   = 1_900_000,
  parameter int HOLDOFF_CYCLES = 3_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic echo,
  output logic trig,
  output logic echo_gate,
  output logic busy,
  output logic done,
  output logic timeout
);

  localparam int MAX_TR  = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
  localparam int MAX_FH  = (FALL_TIMEOUT > HOLDOFF_CYCLES) ? FALL_TIMEOUT : HOLDOFF_CYCLES;
  localparam int MAX_CYC = (MAX_TR > MAX_FH) ? MAX_TR : MAX_FH;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST    = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FALL_LAST    = CNT_W'(FALL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_HOLDOFF
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_echo_m;
  logic             r_echo_s;
  logic             r_trig;
  logic             r_gate;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;

  logic w_trig_end;
  logic w_rise_end;
  logic w_fall_end;
  logic w_hold_end;

  assign w_trig_end = (r_cnt == TRIG_LAST);
  assign w_rise_end = (r_cnt == RISE_LAST);
  assign w_fall_end = (r_cnt == FALL_LAST);
  assign w_hold_end = (r_cnt == HOLDOFF_LAST);

  assign trig      = r_trig;
  assign echo_gate = r_gate;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;

  // echo is asynchronous to clk; only r_echo_s may feed decisions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
    end else begin
      r_echo_m <= echo;
      r_echo_s <= r_echo_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_trig    <= 1'b0;
      r_gate    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_state <= S_TRIG;
            r_trig  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_TRIG: begin
          if (w_trig_end) begin
            r_state <= S_WAIT_RISE;
            r_trig  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // an echo already high on entry counts as the rise
        S_WAIT_RISE: begin
          if (r_echo_s) begin
            r_state <= S_WAIT_FALL;
            r_gate  <= 1'b1;
            r_cnt   <= '0;
          end else if (w_rise_end) begin
            r_state   <= S_HOLDOFF;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // echo fall is tested first so a tie with the limit is not a timeout
        S_WAIT_FALL: begin
          if (!r_echo_s) begin
            r_state   <= S_HOLDOFF;
            r_gate    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end else if (w_fall_end) begin
            r_state   <= S_HOLDOFF;
            r_gate    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (w_hold_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_trig  <= 1'b0;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_trigger_gen.sv
// Bench for sonar_trigger_gen: deadline-based reference model compared every cycle,
// plus directed pings with hand-derived event spacings.
module tb_sonar_trigger_gen;

  localparam int T = 5;
  localparam int R = 20;
  localparam int F = 50;
  localparam int H = 10;

  logic clk;
  logic reset;
  logic start;
  logic echo;
  logic trig;
  logic echo_gate;
  logic busy;
  logic done;
  logic timeout;

  int checks = 0;
  int errors = 0;

  sonar_trigger_gen #(
    .TRIG_CYCLES(T),
    .RISE_TIMEOUT(R),
    .FALL_TIMEOUT(F),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .echo(echo),
    .trig(trig),
    .echo_gate(echo_gate),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with absolute-cycle deadlines
  localparam int P_IDLE = 0;
  localparam int P_TRIG = 1;
  localparam int P_WR   = 2;
  localparam int P_WF   = 3;
  localparam int P_HO   = 4;

  int   m_phase;
  int   m_cyc;
  int   m_end;
  logic m_s1, m_s2, m_es;
  logic m_trig, m_gate, m_busy, m_done, m_to;

  task automatic m_finish(input logic to);
    m_done  = 1'b1;
    m_to    = to;
    m_gate  = 1'b0;
    m_phase = P_HO;
    m_end   = m_cyc + H;
  endtask

  initial begin
    m_cyc = 0; m_end = 0; m_phase = P_IDLE;
    m_s1 = 0; m_s2 = 0; m_es = 0;
    m_trig = 0; m_gate = 0; m_busy = 0; m_done = 0; m_to = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = P_IDLE;
        m_s1 = 0; m_s2 = 0;
        m_trig = 0; m_gate = 0; m_busy = 0; m_done = 0; m_to = 0;
      end else begin
        m_es = m_s2;
        m_s2 = m_s1;
        m_s1 = echo;
        m_cyc++;
        m_done = 1'b0;
        case (m_phase)
          P_IDLE: if (start) begin
            m_phase = P_TRIG; m_trig = 1; m_busy = 1; m_end = m_cyc + T;
          end
          P_TRIG: if (m_cyc == m_end) begin
            m_phase = P_WR; m_trig = 0; m_end = m_cyc + R;
          end
          P_WR: begin
            if (m_es) begin
              m_phase = P_WF; m_gate = 1; m_end = m_cyc + F;
            end else if (m_cyc == m_end) m_finish(1'b1);
          end
          P_WF: begin
            if (!m_es) m_finish(1'b0);
            else if (m_cyc == m_end) m_finish(1'b1);
          end
          default: if (m_cyc == m_end) begin
            m_phase = P_IDLE; m_busy = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("cmp_trig", int'(trig), int'(m_trig));
        chk("cmp_echo_gate", int'(echo_gate), int'(m_gate));
        chk("cmp_busy", int'(busy), int'(m_busy));
        chk("cmp_done", int'(done), int'(m_done));
        chk("cmp_timeout", int'(timeout), int'(m_to));
      end
    end
  end

  // Event monitor: negedge index of the latest edges of each output
  int nc = 0;
  int trig_rise = 0, trig_fall = 0, gate_rise = 0, gate_fall = 0;
  int done_n = 0, busy_fall = 0;
  int trig_rises = 0, gate_rises = 0, dones = 0, done_pairs = 0;
  int done_to = 0;
  logic p_trig = 0, p_gate = 0, p_busy = 0, p_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      nc++;
      if (trig && !p_trig) begin trig_rise = nc; trig_rises++; end
      if (!trig && p_trig) trig_fall = nc;
      if (echo_gate && !p_gate) begin gate_rise = nc; gate_rises++; end
      if (!echo_gate && p_gate) gate_fall = nc;
      if (done) begin done_n = nc; done_to = int'(timeout); dones++; end
      if (done && p_done) done_pairs++;
      if (!busy && p_busy) busy_fall = nc;
      p_trig = trig; p_gate = echo_gate; p_busy = busy; p_done = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_reached"}, int'(busy), 0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    int snap = dones;
    while (dones == snap && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, dones - snap, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b;

  initial begin
    reset = 1'b1; start = 1'b0; echo = 1'b0;
    tick(3);
    chk("rst_trig", int'(trig), 0);
    chk("rst_gate", int'(echo_gate), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    tick(2);

    // Normal ping: echo 8 cycles, starting 6 cycles after trig falls
    b = trig_rises;
    pulse_start();
    tick(5);
    tick(6);
    echo = 1'b1;
    tick(8);
    echo = 1'b0;
    wait_idle(200, "normal");
    chk("normal_trig_width", trig_fall - trig_rise, T);
    chk("normal_gate_delay", gate_rise - trig_fall, 9);
    chk("normal_gate_width", gate_fall - gate_rise, 8);
    chk("normal_done_with_gate_fall", done_n - gate_fall, 0);
    chk("normal_timeout", done_to, 0);
    chk("normal_holdoff", busy_fall - done_n, H);
    chk("normal_one_ping", trig_rises - b, 1);
    tick(3);

    // No echo at all
    b = gate_rises;
    pulse_start();
    wait_idle(200, "noecho");
    chk("noecho_done_delay", done_n - trig_fall, R);
    chk("noecho_timeout", done_to, 1);
    chk("noecho_gate_never", gate_rises - b, 0);
    chk("noecho_holdoff", busy_fall - done_n, H);
    tick(3);

    // Stuck echo: rises and never falls
    pulse_start();
    tick(5);
    tick(3);
    echo = 1'b1;
    wait_idle(200, "stuck");
    chk("stuck_done_delay", done_n - gate_rise, F);
    chk("stuck_gate_fall_same_edge", gate_fall - done_n, 0);
    chk("stuck_timeout", done_to, 1);
    tick(2);

    // Stale echo: still high when the next ping enters WAIT_RISE
    pulse_start();
    tick(5);
    tick(4);
    echo = 1'b0;
    wait_idle(200, "stale");
    chk("stale_gate_immediate", gate_rise - trig_fall, 1);
    chk("stale_gate_fall", gate_fall - trig_fall, 7);
    chk("stale_timeout", done_to, 0);
    tick(3);

    // Start pulses while busy are ignored
    b = trig_rises;
    pulse_start();
    tick(2);
    pulse_start();
    wait_done(200, "reject");
    tick(3);
    pulse_start();
    wait_idle(200, "reject");
    tick(3);
    chk("reject_one_ping", trig_rises - b, 1);
    chk("reject_timeout", done_to, 1);

    // Start held high: back-to-back pings
    b = trig_rises;
    start = 1'b1;
    tick(1);
    wait_idle(200, "cont");
    tick(1);
    chk("cont_retrig_gap", trig_rise - busy_fall, 1);
    chk("cont_two_pings", trig_rises - b, 2);
    start = 1'b0;
    wait_idle(200, "cont2");
    tick(3);

    // Reset in the third trig cycle
    pulse_start();
    tick(2);
    chk("mid_trig_high", int'(trig), 1);
    chk("timeout_held", int'(timeout), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_trig", int'(trig), 0);
    chk("async_gate", int'(echo_gate), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_timeout", int'(timeout), 0);
    tick(2);
    reset = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("post_rst_trig", int'(trig), 1);
    wait_idle(200, "postrst");
    chk("post_rst_trig_width", trig_fall - trig_rise, T);
    chk("post_rst_timeout", done_to, 1);
    tick(3);

    // Tie: echo_s falls on the final WAIT_FALL count
    pulse_start();
    tick(5);
    tick(3);
    echo = 1'b1;
    tick(50);
    echo = 1'b0;
    wait_idle(200, "tie");
    chk("tie_gate_width", gate_fall - gate_rise, F);
    chk("tie_done_delay", done_n - gate_rise, F);
    chk("tie_timeout", done_to, 0);
    tick(3);

    chk("done_never_two_cycles", done_pairs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
